dependency_check: RTL and testbench

// - Decode stage with forwarding control for the 20-bit-instruction pipelined processor.
// - Each cycle it registers one instruction and splits it into opcode, destination, immediate
//   and memory controls.
// - It compares the source registers against the destinations of the two older in-flight

---
 rtl/dependency_check.sv | 105 ++++++++++
 tb/tb_dependency_check.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dependency_check.sv
// Decode stage with operand-forwarding control for the 20-bit-instruction pipeline.
// One instruction is registered per cycle; its sources are compared against the
// destinations of the two older in-flight instructions to pick forwarding paths.
module dependency_check (
  input  logic       clk,
  input  logic       reset,
  input  logic [19:0] ins,
  output logic [1:0] mux_sel_a,
  output logic [1:0] mux_sel_b,
  output logic       imm_sel,
  output logic [7:0] Imm,
  output logic       mem_en_dec,
  output logic       mem_rw_dec,
  output logic       mem_mux_sel_dec,
  output logic [4:0] RW_dec,
  output logic [4:0] op_dec
);

  localparam logic [4:0] OP_LOAD  = 5'b01110;
  localparam logic [4:0] OP_STORE = 5'b01111;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_FWD1 = 2'b01;
  localparam logic [1:0] SEL_FWD2 = 2'b10;

  // Instruction fields
  logic [4:0] op, rw, ra, rb;
  assign op = ins[19:15];
  assign rw = ins[14:10];
  assign ra = ins[9:5];
  assign rb = ins[4:0];

  // 2-back destination and write-valid flags for the 1-back / 2-back slots
  logic [4:0] RW_ex;
  logic       v_dec, v_ex;

  // Next-state values for the registered outputs
  logic [1:0] sel_a_nxt, sel_b_nxt;
  logic       mem_en_nxt, mem_rw_nxt, mem_mux_nxt, wr_nxt;

  // Pick the youngest in-flight producer of register r; 1-back wins over 2-back.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic v1, input logic [4:0] d1,
                                         input logic v2, input logic [4:0] d2);
    if (v1 && r == d1)      return SEL_FWD1;
    else if (v2 && r == d2) return SEL_FWD2;
    else                    return SEL_RF;
  endfunction

  // Forwarding selects and memory-control decode for the incoming instruction
  always_comb begin
    sel_a_nxt   = fwd_sel(ra, v_dec, RW_dec, v_ex, RW_ex);
    sel_b_nxt   = fwd_sel(rb, v_dec, RW_dec, v_ex, RW_ex);
    mem_en_nxt  = 1'b0;
    mem_rw_nxt  = 1'b0;
    mem_mux_nxt = 1'b0;
    wr_nxt      = 1'b1;
    // Immediate form: operand B comes from Imm, so no register forwarding on B
    if (op[4]) sel_b_nxt = SEL_RF;
    case (op)
      OP_LOAD: begin
        mem_en_nxt  = 1'b1;
        mem_mux_nxt = 1'b1;
      end
      OP_STORE: begin
        mem_en_nxt = 1'b1;
        mem_rw_nxt = 1'b1;
        wr_nxt     = 1'b0;   // stores never write the register file
      end
      default: ;
    endcase
  end

  // Decode register plus the two-deep destination history
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_sel_a       <= SEL_RF;
      mux_sel_b       <= SEL_RF;
      imm_sel         <= 1'b0;
      Imm             <= 8'h00;
      mem_en_dec      <= 1'b0;
      mem_rw_dec      <= 1'b0;
      mem_mux_sel_dec <= 1'b0;
      RW_dec          <= 5'd0;
      op_dec          <= 5'd0;
      RW_ex           <= 5'd0;
      v_dec           <= 1'b0;
      v_ex            <= 1'b0;
    end else begin
      RW_ex           <= RW_dec;
      v_ex            <= v_dec;
      RW_dec          <= rw;
      op_dec          <= op;
      Imm             <= ins[7:0];
      v_dec           <= wr_nxt;
      imm_sel         <= op[4];
      mux_sel_a       <= sel_a_nxt;
      mux_sel_b       <= sel_b_nxt;
      mem_en_dec      <= mem_en_nxt;
      mem_rw_dec      <= mem_rw_nxt;
      mem_mux_sel_dec <= mem_mux_nxt;
    end
  end

endmodule

// File: tb/tb_dependency_check.sv
// Bench for dependency_check: directed literal checks followed by randomized
// traffic compared each cycle against a history-queue reference model.
module tb_dependency_check;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins;
  logic [1:0]  mux_sel_a, mux_sel_b;
  logic        imm_sel;
  logic [7:0]  Imm;
  logic        mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
  logic [4:0]  RW_dec, op_dec;

  dependency_check dut (
    .clk(clk), .reset(reset), .ins(ins),
    .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .imm_sel(imm_sel), .Imm(Imm),
    .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
    .RW_dec(RW_dec), .op_dec(op_dec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sa, sb;
    logic       isel;
    logic [7:0] imm;
    logic       men, mrw, mmux;
    logic [4:0] rw, op;
  } out_t;

  typedef struct {
    logic [4:0] rw;
    bit         wr;
  } hist_t;

  out_t  dut_o;
  assign dut_o = {mux_sel_a, mux_sel_b, imm_sel, Imm, mem_en_dec, mem_rw_dec,
                  mem_mux_sel_dec, RW_dec, op_dec};

  int    errors = 0;
  int    checks = 0;
  out_t  pend, cur;
  bit    pend_v = 0, cur_v = 0;
  hist_t hist[$];   // index 0 = most recently issued instruction since reset

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Age (1 or 2) of the youngest older instruction writing r, else 0
  function automatic logic [1:0] src(input logic [4:0] r);
    for (int k = 0; k < hist.size(); k++)
      if (hist[k].wr && hist[k].rw == r) return 2'(k + 1);
    return 2'd0;
  endfunction

  // Apply one instruction for one edge, predict outputs, return after that edge settles
  task automatic issue(input logic r, input logic [19:0] i);
    out_t e;
    logic [4:0] op;
    reset = r;
    ins   = i;
    op    = i[19:15];
    e     = '0;
    if (r) begin
      hist.delete();
    end else begin
      e.sa   = src(i[9:5]);
      e.sb   = op[4] ? 2'd0 : src(i[4:0]);
      e.isel = op[4];
      e.imm  = i[7:0];
      e.men  = (op == 5'd14) || (op == 5'd15);
      e.mrw  = (op == 5'd15);
      e.mmux = (op == 5'd14);
      e.rw   = i[14:10];
      e.op   = op;
      hist.push_front('{rw: i[14:10], wr: (op != 5'd15)});
      if (hist.size() > 2) hist = hist[0:1];
    end
    pend   = e;
    pend_v = 1'b1;
    @(negedge clk);
  endtask

  // Compare DUT against the model on every cycle that carries a fresh prediction
  always begin
    @(posedge clk);
    cur    = pend;
    cur_v  = pend_v;
    pend_v = 1'b0;
    @(negedge clk);
    if (cur_v) chk("model_cmp", 32'(dut_o), 32'(cur));
  end

  function automatic logic [19:0] mk(input logic [4:0] op, rw, ra, rb);
    return {op, rw, ra, rb};
  endfunction

  initial begin
    logic [19:0] i;
    logic [4:0]  op;
    reset = 1'b1;
    ins   = '0;
    @(negedge clk);

    // 1. reset edge, then first instruction
    issue(1'b1, 20'h00443);
    chk("reset_outs", 32'(dut_o), 32'd0);
    issue(1'b0, 20'h00443);
    chk("t1_rw", 32'(RW_dec), 32'd1);
    chk("t1_op", 32'(op_dec), 32'd0);
    chk("t1_sel", 32'({mux_sel_a, mux_sel_b}), 32'h0);
    chk("t1_isel", 32'(imm_sel), 32'd0);

    // 2. immediate op reading the 1-back destination
    issue(1'b0, 20'hA1020);
    chk("t2_op", 32'(op_dec), 32'h14);
    chk("t2_isel", 32'(imm_sel), 32'd1);
    chk("t2_imm", 32'(Imm), 32'h20);
    chk("t2_sel_a", 32'(mux_sel_a), 32'd1);
    chk("t2_sel_b", 32'(mux_sel_b), 32'd0);

    // 3. 2-back on A, 1-back on B; then hold the same instruction
    issue(1'b0, 20'h21424);
    chk("t3_sel_a", 32'(mux_sel_a), 32'd2);
    chk("t3_sel_b", 32'(mux_sel_b), 32'd1);
    chk("t3_rw", 32'(RW_dec), 32'd5);
    issue(1'b0, 20'h21424);
    chk("t3h_sel_a", 32'(mux_sel_a), 32'd0);
    chk("t3h_sel_b", 32'(mux_sel_b), 32'd2);

    // 4. both older destinations match: 1-back wins
    issue(1'b0, 20'h69825);
    chk("t4_sel_b", 32'(mux_sel_b), 32'd1);
    chk("t4_sel_a", 32'(mux_sel_a), 32'd0);

    // 5. LOAD, STORE, then a reader of STORE's RW field
    issue(1'b0, mk(5'b01110, 5'd7, 5'd9, 5'd10));
    chk("t5_load", 32'({mem_en_dec, mem_rw_dec, mem_mux_sel_dec}), 32'b101);
    issue(1'b0, mk(5'b01111, 5'd8, 5'd11, 5'd12));
    chk("t5_store", 32'({mem_en_dec, mem_rw_dec, mem_mux_sel_dec}), 32'b110);
    issue(1'b0, mk(5'd0, 5'd9, 5'd8, 5'd8));
    chk("t5_st_nofwd", 32'({mux_sel_a, mux_sel_b}), 32'h0);

    // 6. reset with a dependent instruction, then no forwarding afterwards
    issue(1'b1, mk(5'd0, 5'd3, 5'd9, 5'd9));
    chk("t6_reset_outs", 32'(dut_o), 32'd0);
    issue(1'b0, mk(5'd0, 5'd2, 5'd0, 5'd0));
    chk("t6_sel", 32'({mux_sel_a, mux_sel_b}), 32'h0);
    chk("t6_rw", 32'(RW_dec), 32'd2);

    // Randomized traffic over a small register set to provoke many matches
    i = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0 || n == 0) begin
        case ($urandom_range(0, 3))
          0:       op = 5'b01110;
          1:       op = 5'b01111;
          default: op = 5'($urandom);
        endcase
        i = mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
      end
      issue($urandom_range(0, 49) == 0, i);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
